muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  unit can accept a request.
REQ-006 Port: op  input  3  op[1:0]: 00 MUL low, 01 MULH high, 10 DIV quotient, 11 REM remainder; op[2] = signed operands.
REQ-007 Port: X  input  WIDTH  multiplicand / dividend.
REQ-008 Port: Y  input  WIDTH  multiplier / divisor.
REQ-009 Port: out_valid  output  1  result present.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: result  output  WIDTH  selected result.
REQ-012 Port: div_zero  output  1  DIV/REM request had Y == 0; qualified by out_valid.

Function
REQ-013 FSM states IDLE, CALC, DONE; in_ready SHALL equal (state == IDLE).
REQ-014 Accept on in_valid && in_ready: X, Y, op registered; IDLE -> CALC, except DIV/REM with Y == 0: IDLE -> DONE.
REQ-015 CALC SHALL run exactly WIDTH iterations (one radix-2 shift-add or restoring-subtract step per cycle), then -> DONE.
REQ-016 Latency: out_valid SHALL rise WIDTH+1 cycles after acceptance edge; 1 cycle for divide-by-zero.
REQ-017 DONE: out_valid = 1, result and div_zero stable until out_valid && out_ready; that edge -> IDLE.
REQ-018 No new request accepted in CALC or DONE; in_valid ignored there.
REQ-019 MUL: result = low WIDTH bits of the 2*WIDTH product; MULH: high WIDTH bits.
REQ-020 DIV: result = quotient truncated toward zero; REM: result = remainder with dividend's sign.
REQ-021 Divide by zero: DIV result all ones, REM result = X, div_zero = 1; div_zero = 0 for all other ops.
REQ-022 Signed overflow (X = most negative, Y = all ones, signed DIV/REM): DIV result = X, REM result = 0, div_zero = 0, normal latency.
REQ-023 Signed ops: operands converted to magnitudes at acceptance, sign applied to final result on CALC -> DONE; MULH signed = high half of signed product.
REQ-024 result SHALL be 0 whenever out_valid = 0.

Reset
REQ-025 reset asserted: state = IDLE, in_ready = 1, out_valid = 0, result = 0, div_zero = 0, all datapath registers cleared, immediately (asynchronous).
REQ-026 reset mid-CALC or in DONE SHALL discard the operation; no out_valid after release.
REQ-027 First request SHALL be accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-028 Macro MULDIV_SIGNED_EN defined: op[2] honoured, signed MUL/MULH/DIV/REM per REQ-022/023.
REQ-029 MULDIV_SIGNED_EN undefined: op[2] ignored, all ops unsigned, no sign-correction logic built; REQ-022 not applicable.

Verification (WIDTH = 32)
REQ-030 MUL X=7 Y=6 -> result 42, out_valid exactly 33 cycles after accept, in_ready low meanwhile.
REQ-031 MULH unsigned X=Y=0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-032 DIV unsigned 100/7 -> 14; REM -> 2; DIV 5/0 -> 0xFFFFFFFF, div_zero=1, out_valid 1 cycle after accept; REM 5/0 -> 5.
REQ-033 With MULDIV_SIGNED_EN: DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; MULH -1*-1 -> 0.
REQ-034 out_ready held low 10 cycles in DONE -> result stable, in_ready low; out_ready high -> IDLE next cycle, back-to-back request accepted.
REQ-035 reset pulsed 10 cycles into CALC -> out_valid never asserts, in_ready = 1 during reset, next request returns correct result.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit: MUL, MULH, DIV, REM in WIDTH cycles, valid/ready handshake.
// Define MULDIV_SIGNED_EN to honour op[2] (signed operands); otherwise every operation is unsigned.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   b_r;       // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc;       // {high/remainder, low/multiplier/quotient}

   logic [WIDTH-1:0]   x_mag;
   logic [WIDTH-1:0]   y_mag;

`ifdef MULDIV_SIGNED_EN
   logic neg_r;
   logic neg_in;
   logic x_neg;
   logic y_neg;

   always_comb begin
      x_neg  = op[2] & X[WIDTH-1];
      y_neg  = op[2] & Y[WIDTH-1];
      x_mag  = x_neg ? -X : X;
      y_mag  = y_neg ? -Y : Y;
      // Remainder takes the dividend's sign; every other result takes the product/quotient sign.
      neg_in = (op[1:0] == 2'b11) ? x_neg : (x_neg ^ y_neg);
   end
`else
   logic unused_op_sign;

   assign unused_op_sign = op[2];
   assign x_mag          = X;
   assign y_mag          = Y;
`endif

   // One iteration of shift-add (multiply) or restoring subtract (divide).
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] step_next;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_trial - {1'b0, b_r};
      if (op_r[1]) begin
         if (div_diff[WIDTH])
            step_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         step_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   logic [WIDTH-1:0] fin_lo;
   logic [WIDTH-1:0] fin_hi;
   logic [WIDTH-1:0] final_res;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      fin_lo = step_next[WIDTH-1:0];
      fin_hi = step_next[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
      if (neg_r) begin
         if (op_r[1]) begin
            fin_lo = -step_next[WIDTH-1:0];
            fin_hi = -step_next[2*WIDTH-1:WIDTH];
         end else begin
            {fin_hi, fin_lo} = -step_next;
         end
      end
`endif
      final_res = op_r[0] ? fin_hi : fin_lo;
   end

   assign in_ready = (state == IDLE);

   // NOTE: sequential state uses non-blocking assignments only; the whole datapath is cleared on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         op_r      <= '0;
         b_r       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         div_zero  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_r     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_r <= op[1:0];
                  if (op[1] && (Y == '0)) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     div_zero  <= 1'b1;
                     result    <= op[0] ? X : '1;
                  end else begin
                     state <= CALC;
                     count <= '0;
                     b_r   <= op[1] ? y_mag : x_mag;
                     acc   <= {{WIDTH{1'b0}}, (op[1] ? x_mag : y_mag)};
`ifdef MULDIV_SIGNED_EN
                     neg_r <= neg_in;
`endif
                  end
               end
            end
            CALC: begin
               acc   <= step_next;
               count <= count + CNT_ONE;
               if (count == CNT_LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= final_res;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  result    <= '0;
                  div_zero  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq at WIDTH = 32 (signed vectors when MULDIV_SIGNED_EN is defined).
module tb_muldiv_seq;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        op = 3'b000;
   logic [WIDTH-1:0]  X = '0;
   logic [WIDTH-1:0]  Y = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH-1:0]  result;
   logic              div_zero;

   int checks = 0;
   int errors = 0;

   muldiv_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .X         (X),
      .Y         (Y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   // Issue one request, report result, div_zero, latency (edges counted from the accept edge as 1)
   // and whether in_ready stayed low while busy; leaves the unit back in IDLE.
   task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] res, output logic dz, output int lat,
                         output logic busy_ok);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      X = x;
      Y = y;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      res = result;
      dz = div_zero;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n;
      #12;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1;
      op = 3'b000;
      X = 32'd2;
      Y = 32'd3;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL first_accept: in_ready got %b want 0", in_ready); end
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++; if (result !== 32'd6) begin errors++; $display("FAIL first_result: got %h want 6", result); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mul();
      logic [WIDTH-1:0] res; logic dz; int lat; logic busy_ok;
      run_op(3'b000, 32'd7, 32'd6, res, dz, lat, busy_ok);
      checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_7x6: got %h want 2a", res); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
      checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL mul_in_ready_low: got %b want 1", busy_ok); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL mul_div_zero: got %b want 0", dz); end
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, lat, busy_ok);
      checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulh_max: got %h want fffffffe", res); end
      run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, lat, busy_ok);
      checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL mul_max: got %h want 00000001", res); end
   endtask

   task automatic test_div();
      logic [WIDTH-1:0] res; logic dz; int lat; logic busy_ok;
      run_op(3'b010, 32'd100, 32'd7, res, dz, lat, busy_ok);
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL div_100_7: got %h want e", res); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_div_zero: got %b want 0", dz); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
      run_op(3'b011, 32'd100, 32'd7, res, dz, lat, busy_ok);
      checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_100_7: got %h want 2", res); end
   endtask

   task automatic test_div_zero();
      logic [WIDTH-1:0] res; logic dz; int lat; logic busy_ok;
      run_op(3'b010, 32'd5, 32'd0, res, dz, lat, busy_ok);
      checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_result: got %h want ffffffff", res); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL divz_flag: got %b want 1", dz); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL divz_latency: got %0d want 1", lat); end
      run_op(3'b011, 32'd5, 32'd0, res, dz, lat, busy_ok);
      checks++; if (res !== 32'd5) begin errors++; $display("FAIL remz_result: got %h want 5", res); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL remz_flag: got %b want 1", dz); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL remz_latency: got %0d want 1", lat); end
   endtask

`ifdef MULDIV_SIGNED_EN
   task automatic test_signed();
      logic [WIDTH-1:0] res; logic dz; int lat; logic busy_ok;
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, res, dz, lat, busy_ok);
      checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2: got %h want fffffffd", res); end
      run_op(3'b111, 32'hFFFF_FFF9, 32'd2, res, dz, lat, busy_ok);
      checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL srem_m7_2: got %h want ffffffff", res); end
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, res, dz, lat, busy_ok);
      checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL sdiv_ovf: got %h want 80000000", res); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL sdiv_ovf_flag: got %b want 0", dz); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL sdiv_ovf_latency: got %0d want 33", lat); end
      run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, res, dz, lat, busy_ok);
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL srem_ovf: got %h want 0", res); end
      run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, lat, busy_ok);
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL smulh_m1: got %h want 0", res); end
      run_op(3'b100, 32'hFFFF_FFFD, 32'd5, res, dz, lat, busy_ok);
      checks++; if (res !== 32'hFFFF_FFF1) begin errors++; $display("FAIL smul_m3_5: got %h want fffffff1", res); end
   endtask
`else
   task automatic test_op2_ignored();
      logic [WIDTH-1:0] res; logic dz; int lat; logic busy_ok;
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, res, dz, lat, busy_ok);
      checks++; if (res !== 32'h7FFF_FFFC) begin errors++; $display("FAIL udiv_op2: got %h want 7ffffffc", res); end
      run_op(3'b111, 32'hFFFF_FFF9, 32'd2, res, dz, lat, busy_ok);
      checks++; if (res !== 32'd1) begin errors++; $display("FAIL urem_op2: got %h want 1", res); end
      run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, lat, busy_ok);
      checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umulh_op2: got %h want fffffffe", res); end
   endtask
`endif

   task automatic test_back_to_back();
      int n;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'b000;
      X = 32'd3;
      Y = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", out_valid); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++; if (result !== 32'd15) begin errors++; $display("FAIL stall_result cycle %0d: got %h want f", i, result); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d: got %b want 0", i, in_ready); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      op = 3'b010;
      X = 32'd100;
      Y = 32'd7;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_idle: got %b want 1", in_ready); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL release_result_zero: got %h want 0", result); end
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: in_ready got %b want 0", in_ready); end
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", n); end
      checks++; if (result !== 32'd14) begin errors++; $display("FAIL b2b_result: got %h want e", result); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_calc();
      logic [WIDTH-1:0] res; logic dz; int lat; logic busy_ok;
      logic seen;
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'b000;
      X = 32'd7;
      Y = 32'd6;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_discard: out_valid seen %b want 0", seen); end
      run_op(3'b010, 32'd100, 32'd7, res, dz, lat, busy_ok);
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL midreset_next: got %h want e", res); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
`ifdef MULDIV_SIGNED_EN
      test_signed();
`else
      test_op2_ignored();
`endif
      test_back_to_back();
      test_reset_mid_calc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
